// File: rtl/nn_digit_sequencer.sv
// nn_digit_sequencer
//
// Puts neural-network classification results on the 7-segment display path.
// Result digits come in over a valid/ready handshake and wait in a small FIFO.
// Each digit then drives the BCD input of display_controller for exactly
// HOLD_CYCLES clocks. Queued digits follow each other with no blank gap, and
// BLANK_CODE is shown whenever nothing is pending.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset (sync release upstream)
//   res_digit    in   [3:0] result digit, BCD 0-9
//   res_valid    in   res_digit valid this cycle
//   res_ready    out  a result can be accepted (combinational: FIFO not full)
//   clr_flags    in   synchronous clear of drop_flag
//   disp_digit   out  [3:0] digit to display_controller.gpio_digit
//   disp_active  out  high while a real digit is shown
//   bad_digit    out  one-cycle pulse: an accepted result was > 9 and discarded
//   drop_flag    out  sticky: res_valid seen while res_ready was low
//   fifo_count   out  entries currently buffered

module nn_digit_sequencer #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [3:0]                         res_digit,
    input  logic                               res_valid,
    output logic                               res_ready,
    input  logic                               clr_flags,
    output logic [3:0]                         disp_digit,
    output logic                               disp_active,
    output logic                               bad_digit,
    output logic                               drop_flag,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);

    localparam logic [CntW-1:0]  FullCount = CntW'(FIFO_DEPTH);
    localparam logic [HoldW-1:0] HoldLast  = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShow
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [3:0]        digit_q, digit_d;
    logic              active_q, active_d;
    logic              bad_q, bad_d;
    logic              drop_q, drop_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        mem_q [FIFO_DEPTH];

    logic              xfer;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;

    // ------------------------------------------------------------------
    // Handshake and FIFO write side
    // ------------------------------------------------------------------
    // Ready ignores a same-cycle pop, so a full FIFO never takes a push.
    assign res_ready     = (cnt_q != FullCount);
    assign fifo_nonempty = (cnt_q != '0);
    assign xfer          = res_valid && res_ready;
    assign push          = xfer && (res_digit <= 4'd9);

    always_comb begin
        bad_d    = xfer && (res_digit > 4'd9);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);

        // Set has priority over clear.
        drop_d = drop_q;
        if (res_valid && !res_ready) begin
            drop_d = 1'b1;
        end else if (clr_flags) begin
            drop_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        digit_d  = digit_q;
        active_d = active_q;
        pop      = 1'b0;

        case (state_q)
            StIdle: begin
                if (fifo_nonempty) begin
                    pop      = 1'b1;
                    hold_d   = '0;
                    digit_d  = mem_q[rd_ptr_q];
                    active_d = 1'b1;
                    state_d  = StShow;
                end
            end
            StShow: begin
                if (hold_q == HoldLast) begin
                    if (fifo_nonempty) begin
                        // Chain straight into the next digit, no blank gap.
                        pop     = 1'b1;
                        hold_d  = '0;
                        digit_d = mem_q[rd_ptr_q];
                    end else begin
                        digit_d  = BLANK_CODE;
                        active_d = 1'b0;
                        state_d  = StIdle;
                    end
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: begin
                digit_d  = BLANK_CODE;
                active_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            digit_q  <= BLANK_CODE;
            active_q <= 1'b0;
            bad_q    <= 1'b0;
            drop_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            digit_q  <= digit_d;
            active_q <= active_d;
            bad_q    <= bad_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while cnt_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= res_digit;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign disp_digit  = digit_q;
    assign disp_active = active_q;
    assign bad_digit   = bad_q;
    assign drop_flag   = drop_q;
    assign fifo_count  = cnt_q;

endmodule

// File: tb/tb_nn_digit_sequencer.sv
// Randomized bench for nn_digit_sequencer (HOLD_CYCLES=4, FIFO_DEPTH=4).
// The reference model keeps a queue of pending digits and counts down the
// display cycles that remain for the current digit.

module tb_nn_digit_sequencer;

    localparam int unsigned Hold  = 4;
    localparam int unsigned Depth = 4;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic            clk;
    logic            rst_n;
    logic [3:0]      res_digit;
    logic            res_valid;
    logic            res_ready;
    logic            clr_flags;
    logic [3:0]      disp_digit;
    logic            disp_active;
    logic            bad_digit;
    logic            drop_flag;
    logic [CntW-1:0] fifo_count;

    nn_digit_sequencer #(
        .HOLD_CYCLES (Hold),
        .FIFO_DEPTH  (Depth),
        .BLANK_CODE  (4'hF)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_digit   (res_digit),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .clr_flags   (clr_flags),
        .disp_digit  (disp_digit),
        .disp_active (disp_active),
        .bad_digit   (bad_digit),
        .drop_flag   (drop_flag),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [3:0] mq[$];
    bit         m_show;
    logic [3:0] m_digit;
    int         m_left;
    bit         m_bad;
    bit         m_drop;

    task automatic model_reset();
        mq.delete();
        m_show  = 1'b0;
        m_digit = 4'hF;
        m_left  = 0;
        m_bad   = 1'b0;
        m_drop  = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [3:0] d, input bit clr);
        bit rdy;
        bit do_pop;
        rdy    = (mq.size() != Depth);
        do_pop = (mq.size() > 0) && (!m_show || m_left == 1);
        if (do_pop) begin
            m_digit = mq.pop_front();
            m_left  = Hold;
            m_show  = 1'b1;
        end else if (m_show) begin
            if (m_left == 1) m_show = 1'b0;
            else m_left--;
        end
        if (v && rdy && d <= 4'd9) mq.push_back(d);
        m_bad = v && rdy && (d > 4'd9);
        if (v && !rdy) m_drop = 1'b1;
        else if (clr) m_drop = 1'b0;
    endtask

    task automatic compare_all();
        check("disp_digit", 32'(disp_digit), m_show ? 32'(m_digit) : 32'hF);
        check("disp_active", 32'(disp_active), 32'(m_show));
        check("res_ready", 32'(res_ready), 32'(mq.size() != Depth));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("bad_digit", 32'(bad_digit), 32'(m_bad));
        check("drop_flag", 32'(drop_flag), 32'(m_drop));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic cycle(input bit v, input logic [3:0] d, input bit clr);
        res_valid = v;
        res_digit = d;
        clr_flags = clr;
        #1;
        check("res_ready_pre", 32'(res_ready), 32'(mq.size() != Depth));
        @(posedge clk);
        model_edge(v, d, clr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0);
    endtask

    task automatic random_run(input int n);
        int dens;
        bit v;
        logic [3:0] d;
        bit clr;
        for (int i = 0; i < n; i++) begin
            case ((i / 300) % 3)
                0:       dens = 10;
                1:       dens = 45;
                default: dens = 90;
            endcase
            v   = ($urandom_range(0, 99) < dens);
            d   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
            clr = ($urandom_range(0, 19) == 0);
            cycle(v, d, clr);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_digit = 4'd0;
        clr_flags = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        #1;
        compare_all();

        // Single digit
        cycle(1'b1, 4'd7, 1'b0);
        idle(6);

        // Back-to-back digits
        cycle(1'b1, 4'd1, 1'b0);
        cycle(1'b1, 4'd2, 1'b0);
        cycle(1'b1, 4'd3, 1'b0);
        idle(14);

        // Overfill, then clear the drop flag
        for (int i = 0; i < 7; i++) cycle(1'b1, 4'(i + 2), 1'b0);
        cycle(1'b0, 4'd0, 1'b1);
        idle(30);

        // Bad digit
        cycle(1'b1, 4'hC, 1'b0);
        idle(3);

        random_run(2700);
        idle(30);

        // Reset while showing 9 with two entries queued
        cycle(1'b1, 4'd9, 1'b0);
        cycle(1'b1, 4'd3, 1'b0);
        cycle(1'b1, 4'd4, 1'b0);
        cycle(1'b0, 4'd0, 1'b0);
        check("pre_reset_digit", 32'(disp_digit), 32'd9);
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_blank", 32'(disp_digit), 32'hF);
        check("async_active", 32'(disp_active), 32'd0);
        check("async_count", 32'(fifo_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all();
        idle(10);

        random_run(900);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something stalls the stimulus.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/nn_digit_sequencer.md
Name: nn_digit_sequencer

Overview:
- Sequences neural-network classification results onto the 7-segment path.
- Accepts result digits from the HPS/GPIO side through a valid/ready handshake and buffers them in a small FIFO.
- Presents each digit on `disp_digit`, the 4-bit BCD input of `display_controller`, for a fixed minimum hold time. Shows a blank code when nothing is pending.
- Sits between the GPIO result interface and `display_controller`, in the `clk` domain (50 MHz).

Parameters:
- HOLD_CYCLES, 50_000_000, clk cycles each digit is shown (1 s at 50 MHz). Must be ≥ 2.
- FIFO_DEPTH, 4, result buffer entries. Power of 2, ≥ 2.
- BLANK_CODE, 4'hF, value driven on `disp_digit` when idle. Must be > 9.

Ports:
- clk  in  1  system clock, 50 MHz, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- res_digit  in  4  NN result digit, BCD 0–9.
- res_valid  in  1  res_digit valid this cycle.
- res_ready  out  1  sequencer can accept a result.
- clr_flags  in  1  synchronous clear of the sticky `drop_flag`.
- disp_digit  out  4  digit to `display_controller.gpio_digit`.
- disp_active  out  1  high while a real digit is shown (state SHOW).
- bad_digit  out  1  one-cycle pulse: an accepted result was > 9 and was discarded.
- drop_flag  out  1  sticky: `res_valid` was seen while `res_ready` = 0.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries currently buffered.

Behaviour:

Reset (async assert, sync release):
- FIFO emptied; fifo_count = 0; state = IDLE.
- disp_digit = BLANK_CODE; disp_active = 0; bad_digit = 0; drop_flag = 0.
- res_ready = 1 (combinational: not full).

Handshake and FIFO write:
- Transfer occurs on a rising edge with res_valid && res_ready.
- res_ready = (fifo_count != FIFO_DEPTH). It does not depend on a same-cycle pop, so no push happens when full.
- On transfer with res_digit ≤ 9: write to FIFO tail, fifo_count + 1.
- On transfer with res_digit > 9: no write; bad_digit = 1 for the next cycle only.
- res_valid && !res_ready: result lost; drop_flag set on that edge. It stays set until reset or clr_flags = 1. If set and clear coincide, set wins.

FSM:
- IDLE:
  - disp_digit = BLANK_CODE, disp_active = 0.
  - If the FIFO is non-empty: pop the head into the display register, clear hold_cnt, go to SHOW.
- SHOW:
  - disp_digit = latched digit, disp_active = 1.
  - hold_cnt increments each cycle from 0.
  - When hold_cnt = HOLD_CYCLES-1: if the FIFO is non-empty, pop the next digit, reload hold_cnt = 0 and stay in SHOW (no blank gap). Otherwise go to IDLE.
  - Each digit is therefore displayed exactly HOLD_CYCLES cycles.

Timing:
- Simultaneous push and pop in one edge: fifo_count unchanged, both operations take effect.
- Latency: a result written at edge N into an empty FIFO while IDLE appears on disp_digit after edge N+1.
- hold_cnt width: $clog2(HOLD_CYCLES). Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- All outputs are registered except res_ready.
- Reset asserted mid-SHOW: display blanks immediately (asynchronously) and buffered digits are discarded.

Test Plan (HOLD_CYCLES=4, FIFO_DEPTH=4):
1. Reset: hold rst_n = 0, then release → disp_digit = 4'hF, disp_active = 0, res_ready = 1, fifo_count = 0, drop_flag = 0.
2. Single digit: push 7 at edge N → disp_digit = 7 and disp_active = 1 from N+1 through N+4; at N+5 disp_digit = 4'hF, disp_active = 0.
3. Back-to-back: push 1, 2, 3 on consecutive edges → disp_digit shows 1, 2, 3 for 4 cycles each with no blank between; fifo_count peaks at 2; then 4'hF.
4. Full FIFO: push 5 results while the first is showing → res_ready = 0 when fifo_count = 4; the 6th res_valid sets drop_flag; one clr_flags pulse clears it.
5. Bad digit: push res_digit = 4'hC → bad_digit pulses for exactly one cycle, fifo_count stays 0, display stays blank.
6. Reset mid-operation: pull rst_n low while showing 9 with 2 entries queued → disp_digit = 4'hF at once; fifo_count = 0 after release; no stale digits displayed.
